// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_select.sv
// Fetch/data priority decision: data port wins ties until its contested streak saturates.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4,
  parameter int STREAK_W      = $clog2(MAX_DM_STREAK + 1)
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STREAK_W-1:0] streak,
  output grant_t              grant
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  always_comb begin
    grant = GNT_DM;
    if (if_req && !dm_req) begin
      grant = GNT_IF;
    end else if (if_req && dm_req && (streak == STREAK_MAX)) begin
      grant = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data RAM between fetch (read-only) and memory-stage ports via a fixed-latency window.
// Optional conflict counter output enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int RAM_LATENCY   = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_conflicts
`endif
);

  localparam int CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [CNT_W-1:0]    LAT_M1     = CNT_W'(RAM_LATENCY - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  grant_t              gnt_q, gnt_d, gnt_sel;
  logic                we_q, we_d;
  logic [STREAK_W-1:0] streak;
  logic                start, capture;

  mem_arb_select #(
    .MAX_DM_STREAK (MAX_DM_STREAK),
    .STREAK_W      (STREAK_W)
  ) u_select (
    .if_req (if_req),
    .dm_req (dm_req),
    .streak (streak),
    .grant  (gnt_sel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gnt_d   = gnt_q;
    we_d    = we_q;
    start   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          start   = 1'b1;
          state_d = ACCESS;
          cnt_d   = LAT_M1;
          gnt_d   = gnt_sel;
          we_d    = (gnt_sel == GNT_DM) && dm_we;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access window: RAM controls are registered so they are steady for the whole ACCESS phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_q     <= GNT_IF;
      we_q      <= 1'b0;
      streak    <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      gnt_q  <= gnt_d;
      we_q   <= we_d;
      ram_en <= (state_d == ACCESS);
      ram_we <= (state_d == ACCESS) && we_d;
      if_ack <= (state_d == RESP) && (gnt_q == GNT_IF);
      dm_ack <= (state_d == RESP) && (gnt_q == GNT_DM);
      if (start) begin
        if (gnt_sel == GNT_DM) begin
          ram_addr  <= dm_addr;
          ram_wdata <= dm_wdata;
          if (if_req && (streak != STREAK_MAX)) begin
            streak <= streak + STREAK_W'(1);
          end
        end else begin
          ram_addr <= if_addr;
          streak   <= '0;
        end
      end
      if (capture) begin
        if (gnt_q == GNT_IF) begin
          if_rdata <= ram_rdata;
        end else if (!we_q) begin
          dm_rdata <= ram_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_conflicts <= '0;
    end else if (start && if_req && dm_req && (perf_conflicts != 16'hFFFF)) begin
      perf_conflicts <= perf_conflicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-1 instance with a RAM model and a latency-3 instance.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  always #5 clock = ~clock;

  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [8:0]  if_addr = '0, dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        if_ack, dm_ack, ram_en, ram_we;
  logic [31:0] if_rdata, dm_rdata, ram_wdata, ram_rdata;
  logic [8:0]  ram_addr;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_conflicts;
`endif

  logic        l3_if_req = 1'b0, l3_dm_req = 1'b0, l3_dm_we = 1'b0;
  logic [8:0]  l3_if_addr = '0, l3_dm_addr = '0;
  logic [31:0] l3_dm_wdata = '0, l3_ram_rdata = '0;
  logic        l3_if_ack, l3_dm_ack, l3_ram_en, l3_ram_we;
  logic [31:0] l3_if_rdata, l3_dm_rdata, l3_ram_wdata;
  logic [8:0]  l3_ram_addr;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] l3_perf_conflicts;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [512];

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
      mem[9'h010] <= 32'hDEADBEEF;
      mem[9'h005] <= 32'h00000055;
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LATENCY(1), .MAX_DM_STREAK(4)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflicts(perf_conflicts)
`endif
  );

  mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LATENCY(3), .MAX_DM_STREAK(4)) u_dut3 (
    .clock(clock), .reset(reset),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ack(l3_if_ack), .if_rdata(l3_if_rdata),
    .dm_req(l3_dm_req), .dm_we(l3_dm_we), .dm_addr(l3_dm_addr), .dm_wdata(l3_dm_wdata),
    .dm_ack(l3_dm_ack), .dm_rdata(l3_dm_rdata),
    .ram_en(l3_ram_en), .ram_we(l3_ram_we), .ram_addr(l3_ram_addr), .ram_wdata(l3_ram_wdata),
    .ram_rdata(l3_ram_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflicts(l3_perf_conflicts)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %0b want 0", ram_en); end
    checks++; if ({if_ack, dm_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {if_ack, dm_ack}); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    checks++; if (ram_addr !== 9'h0 || ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_ram_bus: got %h/%h want 0/0", ram_addr, ram_wdata); end
    checks++; if (l3_ram_en !== 1'b0) begin errors++; $display("FAIL reset_l3_ram_en: got %0b want 0", l3_ram_en); end
    reset = 1'b1;
    step();
    // Mid-access reset on a data read of address 5
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h005;
    step();
    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL midrst_access: got %0b want 1", ram_en); end
    reset = 1'b0;
    #1;
    checks++; if (ram_en !== 1'b0 || ram_addr !== 9'h0) begin errors++; $display("FAIL midrst_async: got en=%0b addr=%h want 0/0", ram_en, ram_addr); end
    step();
    checks++; if (dm_ack !== 1'b0 || if_ack !== 1'b0) begin errors++; $display("FAIL midrst_noack: got %b want 00", {if_ack, dm_ack}); end
    reset = 1'b1;
    step();
    checks++; if (ram_en !== 1'b1 || ram_addr !== 9'h005 || dm_ack !== 1'b0) begin errors++; $display("FAIL midrst_reissue: got en=%0b addr=%h ack=%0b want 1/005/0", ram_en, ram_addr, dm_ack); end
    step();
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h00000055) begin errors++; $display("FAIL midrst_ack: got ack=%0b data=%h want 1/00000055", dm_ack, dm_rdata); end
    dm_req = 1'b0;
    step();
    checks++; if (dm_ack !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL midrst_idle: got ack=%0b en=%0b want 0/0", dm_ack, ram_en); end
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 9'h010;
    step();
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 9'h010) begin errors++; $display("FAIL fetch_access: got en=%0b we=%0b addr=%h want 1/0/010", ram_en, ram_we, ram_addr); end
    checks++; if (if_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack: got %0b want 0", if_ack); end
    step();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_resp: got ack=%0b data=%h want 1/deadbeef", if_ack, if_rdata); end
    checks++; if (dm_ack !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL fetch_resp_ctl: got dm_ack=%0b en=%0b want 0/0", dm_ack, ram_en); end
    if_req = 1'b0;
    step();
    checks++; if (if_ack !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_pulse: got ack=%0b data=%h want 0/deadbeef", if_ack, if_rdata); end
  endtask

  task automatic test_write_read();
    int we_cycles = 0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h1FF; dm_wdata = 32'h12345678;
    step();
    if (ram_we === 1'b1) we_cycles++;
    checks++; if (ram_en !== 1'b1 || ram_addr !== 9'h1FF || ram_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_access: got en=%0b addr=%h wdata=%h want 1/1ff/12345678", ram_en, ram_addr, ram_wdata); end
    step();
    if (ram_we === 1'b1) we_cycles++;
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h00000055) begin errors++; $display("FAIL wr_ack: got ack=%0b rdata=%h want 1/00000055", dm_ack, dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    if (ram_we === 1'b1) we_cycles++;
    checks++; if (we_cycles != 1) begin errors++; $display("FAIL wr_strobe_len: got %0d cycles want 1", we_cycles); end
    checks++; if (ram_wdata !== 32'h12345678 || ram_addr !== 9'h1FF) begin errors++; $display("FAIL wr_hold_bus: got %h/%h want 1ff/12345678", ram_addr, ram_wdata); end
    dm_req = 1'b1; dm_addr = 9'h1FF; dm_wdata = 32'hFFFFFFFF;
    step();
    checks++; if (ram_we !== 1'b0 || ram_en !== 1'b1) begin errors++; $display("FAIL rd_access: got we=%0b en=%0b want 0/1", ram_we, ram_en); end
    step();
    checks++; if (dm_ack !== 1'b1 || dm_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_back: got ack=%0b data=%h want 1/12345678", dm_ack, dm_rdata); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_if_untouched: got %h want deadbeef", if_rdata); end
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_dm = 6'b101111;
    if_req = 1'b1; if_addr = 9'h010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h005;
    for (int g = 0; g < 6; g++) begin
      step();
      checks++; if (ram_addr !== (exp_dm[g] ? 9'h005 : 9'h010)) begin errors++; $display("FAIL arb_addr_%0d: got %h want %h", g, ram_addr, exp_dm[g] ? 9'h005 : 9'h010); end
      step();
      checks++; if ({if_ack, dm_ack} !== (exp_dm[g] ? 2'b01 : 2'b10)) begin errors++; $display("FAIL arb_grant_%0d: got if/dm=%b want %b", g, {if_ack, dm_ack}, exp_dm[g] ? 2'b01 : 2'b10); end
      step();
      checks++; if ({if_ack, dm_ack} !== 2'b00) begin errors++; $display("FAIL arb_idle_%0d: got if/dm=%b want 00", g, {if_ack, dm_ack}); end
    end
    if_req = 1'b0; dm_req = 1'b0;
    step();
  endtask

  task automatic test_latency3();
    l3_if_req = 1'b1; l3_if_addr = 9'h0AB; l3_ram_rdata = 32'h0;
    step();
    checks++; if (l3_ram_en !== 1'b1 || l3_ram_addr !== 9'h0AB) begin errors++; $display("FAIL l3_c1: got en=%0b addr=%h want 1/0ab", l3_ram_en, l3_ram_addr); end
    l3_ram_rdata = 32'h11111111;
    step();
    checks++; if (l3_ram_en !== 1'b1 || l3_ram_addr !== 9'h0AB || l3_if_ack !== 1'b0) begin errors++; $display("FAIL l3_c2: got en=%0b addr=%h ack=%0b want 1/0ab/0", l3_ram_en, l3_ram_addr, l3_if_ack); end
    l3_ram_rdata = 32'h22222222;
    step();
    checks++; if (l3_ram_en !== 1'b1 || l3_ram_addr !== 9'h0AB || l3_if_ack !== 1'b0) begin errors++; $display("FAIL l3_c3: got en=%0b addr=%h ack=%0b want 1/0ab/0", l3_ram_en, l3_ram_addr, l3_if_ack); end
    l3_ram_rdata = 32'hCAFEF00D;
    step();
    checks++; if (l3_if_ack !== 1'b1 || l3_if_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL l3_c4: got ack=%0b data=%h want 1/cafef00d", l3_if_ack, l3_if_rdata); end
    checks++; if (l3_ram_en !== 1'b0 || l3_dm_ack !== 1'b0) begin errors++; $display("FAIL l3_resp_ctl: got en=%0b dm_ack=%0b want 0/0", l3_ram_en, l3_dm_ack); end
    l3_if_req = 1'b0; l3_ram_rdata = 32'h0;
    step();
    checks++; if (l3_if_ack !== 1'b0 || l3_if_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL l3_after: got ack=%0b data=%h want 0/cafef00d", l3_if_ack, l3_if_rdata); end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    step();
    checks++; if (perf_conflicts !== 16'h0) begin errors++; $display("FAIL perf_reset: got %0d want 0", perf_conflicts); end
    reset = 1'b1;
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    for (int g = 0; g < 10; g++) begin
      step(); step(); step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    step(); step();
    checks++; if (perf_conflicts !== 16'd10) begin errors++; $display("FAIL perf_count: got %0d want 10", perf_conflicts); end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_read();
    test_write_read();
    test_back_to_back();
    test_latency3();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 512x32 data RAM between the instruction-fetch port (read-only) and the memory-stage port (read/write).
- Sequences every RAM access through a fixed-latency access window.
- Returns read data with a one-cycle ack pulse.
- The pipeline holds its stage while its req is high and ack is low.

Parameters:
- ADDR_W, 9, RAM word-address width.
- DATA_W, 32, data width.
- RAM_LATENCY, 1, cycles ram_en/ram_addr must be held before ram_rdata is valid (>=1).
- MAX_DM_STREAK, 4, consecutive contested data-port grants allowed before fetch wins a tie (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request, held until if_ack.
- if_addr  in  ADDR_W  fetch word address, stable while if_req.
- if_ack  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetch read data, registered.
- dm_req  in  1  memory-stage request, held until dm_ack.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  write data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DATA_W  data read result, registered.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, streak=0, latency counter=0. An in-flight access is abandoned with no ack; requesters reissue.
- FSM:
  - IDLE: no req -> stay. Any req -> register grant, address, we, wdata onto ram_* -> ACCESS, cnt=RAM_LATENCY-1.
  - ACCESS: ram_en=1 and ram_* held constant. cnt>0 -> decrement. cnt==0 -> capture ram_rdata into granted port's rdata (reads only) -> RESP.
  - RESP: granted ack=1 for exactly this cycle; ram_en=0, ram_we=0; requests ignored -> IDLE.
- Latency: req first seen in cycle 0 -> ack in cycle RAM_LATENCY+1. Peak throughput is one access per RAM_LATENCY+2 cycles.
- ram_we=1 only in ACCESS with a granted dm write. Outside ACCESS, ram_en=ram_we=0, and ram_addr/ram_wdata hold their last value.
- Arbitration (evaluated in IDLE only):
  - Single requester wins.
  - Both requesting: dm wins unless streak==MAX_DM_STREAK, then if wins.
  - streak increments on a dm grant made while if_req=1, saturating at MAX_DM_STREAK. It clears on any if grant.
- dm write: dm_ack pulses and dm_rdata is unchanged. if_rdata changes only on an if read completion.
- A req dropped before ack is a protocol violation; the granted access still completes and acks.
- At most one ack is high in any cycle; never both.

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds output perf_conflicts (16 bits), counting IDLE grant cycles with if_req and dm_req both high.
  - Saturates at 0xFFFF; cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), grant encoding (GNT_IF, GNT_DM), ADDR_W/DATA_W defaults.
- Sub-module mem_arb_select: combinational priority/streak decision (inputs if_req, dm_req, streak; output grant). It isolates the fairness logic for unit test. Everything else stays in the top module.

Test Plan:
- Reset mid-access: assert reset in ACCESS -> all outputs 0 next edge, no ack; after release with dm_req held -> fresh access, dm_ack 2 cycles later.
- Single fetch read: if_req=1, if_addr=0x010, RAM[0x010]=0xDEADBEEF, RAM_LATENCY=1 -> ram_en high cycle 1, if_ack and if_rdata=0xDEADBEEF in cycle 2.
- Data write then read: dm write addr 0x1FF data 0x12345678 -> ram_we=1 for exactly 1 cycle, dm_ack pulse, dm_rdata unchanged. Read of 0x1FF -> dm_rdata=0x12345678.
- Simultaneous requests (MAX_DM_STREAK=4) with dm re-requesting every time: grant order dm,dm,dm,dm,if,dm... Confirm no cycle with both acks high.
- RAM_LATENCY=3: ram_addr stable for 3 ACCESS cycles, ack in cycle 4, ram_rdata sampled only at the last ACCESS cycle (change it earlier -> must not affect result).
- MEM_ARB_PERF_EN: 10 contested grants -> perf_conflicts=10; 70000 contested grants -> 0xFFFF.
